slc3_mem_responder: RTL and testbench
=====================================

// Module: slc3_mem_responder
// PURPOSE
//  Memory/IO responder answering the SLC-3 datapath's MAR/MDR memory requests.
//  Holds the on-chip word RAM and the memory-mapped IO: switches (read) and hex display (write) at 0xFFFF.
//  Its Data_to_CPU output drives the datapath's MDR_In.
//  A REQ/RDY handshake with a programmable number of wait states models slow SRAM timing.
// PARAMETERS
//  ADDR_W       10   RAM address bits; RAM DEPTH = 2**ADDR_W words of 16 bits
//  WAIT_STATES  2    cycles inserted between request capture and access (0..15)
//  IO_ADDR      16'hFFFF  memory-mapped IO address (switches read / hex write)
// PORTS
//  Clk            in   1   system clock, rising edge
//  Reset          in   1   asynchronous, active-low reset
//  MEM_REQ        in   1   access request; ADDR/MEM_WE/Data_from_CPU valid while high
//  MEM_WE         in   1   1 = write, 0 = read
//  ADDR           in   16  word address (datapath MAR)
//  Data_from_CPU  in   16  write data (datapath MDR)
//  Switches       in   16  asynchronous board switches
//  MEM_RDY        out  1   one-cycle completion strobe
//  Data_to_CPU    out  16  read data, valid from the MEM_RDY cycle until the next read completes
//  HEX_Data       out  16  hex display register
//  ADDR_ERR       out  1   sticky: an access hit an unmapped address; cleared by reset only
// BEHAVIOUR
//  Reset (async, Reset=0) sets these values:
//   - state = IDLE; MEM_RDY = 0; Data_to_CPU = 0; HEX_Data = 0; ADDR_ERR = 0
//   - switch synchroniser flops = 0; wait counter = 0
//   - RAM contents are NOT reset; the simulation model initialises RAM to 0.
//  Switches pass through a 2-flop synchroniser; reads of IO_ADDR return the synchronised value.
//  FSM, evaluated on Clk rising edge:
//   - IDLE: MEM_REQ=1 latches ADDR, MEM_WE, Data_from_CPU and loads cnt = WAIT_STATES.
//     Next state is WAIT if WAIT_STATES>0, else ACCESS. MEM_REQ is sampled ONLY in IDLE.
//   - WAIT: cnt decrements each cycle; at cnt==1 go to ACCESS. Input changes are ignored (latched copy used).
//   - ACCESS: perform the access using the latched values, then go to DONE:
//       write, ADDR < DEPTH        -> RAM[ADDR] <= data
//       write, ADDR == IO_ADDR     -> HEX_Data <= data
//       read,  ADDR < DEPTH        -> Data_to_CPU <= RAM[ADDR]
//       read,  ADDR == IO_ADDR     -> Data_to_CPU <= synchronised switches
//       any other address          -> write dropped / read returns 16'h0000, ADDR_ERR <= 1
//     A write leaves Data_to_CPU unchanged.
//   - DONE: MEM_RDY = 1 (decoded from state, exactly one cycle); next state is IDLE.
//  Latency: MEM_RDY is high in the cycle after the (WAIT_STATES+1)th edge following the capture edge.
//   This gives WAIT_STATES+2 edges per access including the IDLE return.
//  Handshake:
//   - The requester must drop MEM_REQ in the MEM_RDY cycle.
//   - If MEM_REQ is still high in IDLE, a new (repeat) access starts with no gap (back-to-back allowed).
//  Reset mid-operation:
//   - Reset asserted before the ACCESS edge: no RAM/HEX write is committed; MEM_RDY is never asserted.
//   - Reset asserted in DONE: RDY drops immediately.
//  Width rules: ADDR bits above ADDR_W must be zero for a RAM hit; no aliasing.
//  Read-during-write does not occur: accesses are strictly serialised.
// TESTING
//  1) WAIT_STATES=2, write 16'hBEEF to 0x0005, then read 0x0005.
//     -> Data_to_CPU = 16'hBEEF; MEM_RDY high exactly 1 cycle, 3 edges after each capture edge.
//  2) Switches = 16'h1234, read 0xFFFF -> Data_to_CPU = 16'h1234; HEX_Data unchanged (0).
//  3) Write 16'h00A5 to 0xFFFF -> HEX_Data = 16'h00A5 after the ACCESS edge; RAM untouched (read 0x03FF unchanged).
//  4) ADDR_W=10, read 0x0400 -> Data_to_CPU = 0, ADDR_ERR = 1 and it stays 1 across later good accesses.
//  5) Start a write of 16'h5555 to 0x0010, pulse Reset low during WAIT.
//     -> no MEM_RDY; a subsequent read of 0x0010 returns its prior value.
//  6) Hold MEM_REQ high for 2 requests, WAIT_STATES=0.
//     -> MEM_RDY pulses every 3 cycles; data matches each access in order.

Source files
------------

// File: rtl/slc3_mem_responder.sv
// Memory/IO responder for the SLC-3 datapath: word RAM plus switch/hex IO at IO_ADDR,
// answered through a REQ/RDY handshake with programmable wait states.
module slc3_mem_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MEM_REQ,
  input  logic        MEM_WE,
  input  logic [15:0] ADDR,
  input  logic [15:0] Data_from_CPU,
  input  logic [15:0] Switches,
  output logic        MEM_RDY,
  output logic [15:0] Data_to_CPU,
  output logic [15:0] HEX_Data,
  output logic        ADDR_ERR
);

  localparam int unsigned Depth   = 2 ** ADDR_W;
  localparam logic [3:0]  WaitCnt = 4'(WAIT_STATES);

  typedef enum logic [1:0] {StIdle, StWait, StAccess, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic [15:0] hex_q, hex_d;
  logic        err_q, err_d;
  logic [15:0] sw_meta_q, sw_sync_q;

  logic [15:0] mem [Depth];
  logic        ram_we;
  logic        ram_hit;
  logic        io_hit;
  logic [15:0] ram_rdata;

  // Upper address bits must be clear for a RAM hit so nothing aliases into the array.
  assign ram_hit   = (addr_q >> ADDR_W) == 16'd0;
  assign io_hit    = addr_q == IO_ADDR;
  assign ram_rdata = mem[addr_q[ADDR_W-1:0]];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    hex_d   = hex_q;
    err_d   = err_q;
    ram_we  = 1'b0;
    case (state_q)
      StIdle: begin
        if (MEM_REQ) begin
          addr_d  = ADDR;
          we_d    = MEM_WE;
          wdata_d = Data_from_CPU;
          cnt_d   = WaitCnt;
          state_d = (WaitCnt != 4'd0) ? StWait : StAccess;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StAccess;
      end
      StAccess: begin
        state_d = StDone;
        if (ram_hit) begin
          if (we_q) ram_we = 1'b1;
          else      rdata_d = ram_rdata;
        end else if (io_hit) begin
          if (we_q) hex_d = wdata_q;
          else      rdata_d = sw_sync_q;
        end else begin
          err_d = 1'b1;
          if (!we_q) rdata_d = 16'h0000;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      addr_q    <= 16'h0000;
      we_q      <= 1'b0;
      wdata_q   <= 16'h0000;
      rdata_q   <= 16'h0000;
      hex_q     <= 16'h0000;
      err_q     <= 1'b0;
      sw_meta_q <= 16'h0000;
      sw_sync_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      hex_q     <= hex_d;
      err_q     <= err_d;
      sw_meta_q <= Switches;
      sw_sync_q <= sw_meta_q;
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge Clk) begin
    if (ram_we) mem[addr_q[ADDR_W-1:0]] <= wdata_q;
  end

  assign MEM_RDY     = state_q == StDone;
  assign Data_to_CPU = rdata_q;
  assign HEX_Data    = hex_q;
  assign ADDR_ERR    = err_q;

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Directed bench for slc3_mem_responder: a WAIT_STATES=2 instance for the main sequence
// and a WAIT_STATES=0 instance for back-to-back requests.
module tb_slc3_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [15:0] addr, wdata, sw;
  logic        rdy, err;
  logic [15:0] rdata, hex;

  logic        req0, we0;
  logic [15:0] addr0, wdata0;
  logic        rdy0, err0;
  logic [15:0] rdata0, hex0;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  slc3_mem_responder #(.ADDR_W(10), .WAIT_STATES(2), .IO_ADDR(16'hFFFF)) dut (
    .Clk(clk), .Reset(rst_n), .MEM_REQ(req), .MEM_WE(we), .ADDR(addr),
    .Data_from_CPU(wdata), .Switches(sw), .MEM_RDY(rdy), .Data_to_CPU(rdata),
    .HEX_Data(hex), .ADDR_ERR(err)
  );

  slc3_mem_responder #(.ADDR_W(10), .WAIT_STATES(0), .IO_ADDR(16'hFFFF)) dut0 (
    .Clk(clk), .Reset(rst_n), .MEM_REQ(req0), .MEM_WE(we0), .ADDR(addr0),
    .Data_from_CPU(wdata0), .Switches(sw), .MEM_RDY(rdy0), .Data_to_CPU(rdata0),
    .HEX_Data(hex0), .ADDR_ERR(err0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // One access on the WAIT_STATES=2 instance; checks RDY latency and one-cycle width.
  task automatic do_access(input logic w, input logic [15:0] a, input logic [15:0] d,
                           output logic [15:0] rd);
    int n;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 20);
    req = 1'b0;
    rd  = rdata;
    chk("latency", n, 4);
    @(posedge clk); #1;
    chk("rdy_width", {31'd0, rdy}, 0);
  endtask

  // Two requests with MEM_REQ held high on the WAIT_STATES=0 instance.
  task automatic b2b(input logic w, input logic [15:0] a0, input logic [15:0] d0,
                     input logic [15:0] a1, input logic [15:0] d1,
                     input logic [15:0] e0, input logic [15:0] e1);
    @(negedge clk);
    req0 = 1'b1; we0 = w; addr0 = a0; wdata0 = d0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin addr0 = a1; wdata0 = d1; end
      if (i == 5) req0 = 1'b0;
      chk("b2b_rdy", {31'd0, rdy0}, {31'd0, (i == 2 || i == 5)});
      if (i == 2 && !w) chk("b2b_data0", {16'd0, rdata0}, {16'd0, e0});
      if (i == 5 && !w) chk("b2b_data1", {16'd0, rdata0}, {16'd0, e1});
    end
  endtask

  logic [15:0] rd;

  initial begin
    rst_n = 1'b0;
    req = 1'b0; we = 1'b0; addr = 16'h0; wdata = 16'h0; sw = 16'h1234;
    req0 = 1'b0; we0 = 1'b0; addr0 = 16'h0; wdata0 = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", {31'd0, rdy}, 0);
    chk("rst_data", {16'd0, rdata}, 0);
    chk("rst_hex", {16'd0, hex}, 0);
    chk("rst_err", {31'd0, err}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1) write then read RAM
    do_access(1'b1, 16'h0005, 16'hBEEF, rd);
    chk("w5_data_kept", {16'd0, rd}, 0);
    do_access(1'b0, 16'h0005, 16'h0000, rd);
    chk("r5", {16'd0, rd}, 32'hBEEF);

    // 2) switch read
    do_access(1'b0, 16'hFFFF, 16'h0000, rd);
    chk("sw_read", {16'd0, rd}, 32'h1234);
    chk("hex_still0", {16'd0, hex}, 0);

    // 3) hex write leaves RAM and read data alone
    do_access(1'b1, 16'h03FF, 16'h7777, rd);
    chk("w3ff_data_kept", {16'd0, rd}, 32'h1234);
    do_access(1'b1, 16'hFFFF, 16'h00A5, rd);
    chk("hex_write", {16'd0, hex}, 32'h00A5);
    do_access(1'b0, 16'h03FF, 16'h0000, rd);
    chk("r3ff", {16'd0, rd}, 32'h7777);
    chk("err_clean", {31'd0, err}, 0);

    // 4) unmapped read, sticky error
    do_access(1'b0, 16'h0400, 16'h0000, rd);
    chk("bad_rdata", {16'd0, rd}, 0);
    chk("err_set", {31'd0, err}, 1);
    do_access(1'b0, 16'h0005, 16'h0000, rd);
    chk("r5_again", {16'd0, rd}, 32'hBEEF);
    chk("err_sticky", {31'd0, err}, 1);
    do_access(1'b1, 16'h8005, 16'h4321, rd);
    do_access(1'b0, 16'h0005, 16'h0000, rd);
    chk("no_alias", {16'd0, rd}, 32'hBEEF);

    // 5) reset during WAIT aborts the write
    do_access(1'b1, 16'h0010, 16'h1111, rd);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 16'h0010; wdata = 16'h5555;
    @(posedge clk); #1;
    req = 1'b0;
    chk("abort_rdy_a", {31'd0, rdy}, 0);
    @(posedge clk); #1;
    chk("abort_rdy_b", {31'd0, rdy}, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_err_clr", {31'd0, err}, 0);
    chk("abort_hex_clr", {16'd0, hex}, 0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("abort_rdy_rst", {31'd0, rdy}, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("abort_rdy_after", {31'd0, rdy}, 0);
    end
    do_access(1'b0, 16'h0010, 16'h0000, rd);
    chk("r10_prior", {16'd0, rd}, 32'h1111);

    // 6) back-to-back, WAIT_STATES=0
    b2b(1'b1, 16'h0001, 16'hAAAA, 16'h0002, 16'hBBBB, 16'h0, 16'h0);
    repeat (2) @(negedge clk);
    b2b(1'b0, 16'h0001, 16'h0000, 16'h0002, 16'h0000, 16'hAAAA, 16'hBBBB);
    chk("b2b_err", {31'd0, err0}, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
